// File: rtl/tb_status_periph_pkg.sv
// Shared definitions for the testbench status peripheral: register offsets,
// register-select decode and default magic values.
package tb_status_periph_pkg;

  localparam logic [3:0] OFF_PRINT  = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_EXIT   = 4'h8;
  localparam logic [3:0] OFF_CYCLE  = 4'hC;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] DEF_FAIL_MAGIC = 32'd1;

  typedef enum logic [2:0] {
    SEL_PRINT,
    SEL_STATUS,
    SEL_EXIT,
    SEL_CYCLE,
    SEL_NONE
  } reg_sel_e;

  // Select a register only when the upper address bits hit the 16-byte window.
  function automatic reg_sel_e decode_sel(input logic [27:0] addr_hi,
                                          input logic [27:0] base_hi,
                                          input logic [1:0]  word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr_hi == base_hi) begin
      case ({word, 2'b00})
        OFF_PRINT:  sel = SEL_PRINT;
        OFF_STATUS: sel = SEL_STATUS;
        OFF_EXIT:   sel = SEL_EXIT;
        OFF_CYCLE:  sel = SEL_CYCLE;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/tb_status_periph_if.sv
// Core data-bus port of the status peripheral: req/gnt request phase plus a
// one-cycle-later rvalid/rdata response phase.
interface tb_status_periph_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/tb_char_fifo.sv
// Small synchronous FIFO for stdout characters. Pointers carry an extra wrap
// bit so full and empty are distinguished by the level alone.
module tb_char_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth):0]     o_level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullLevel = (AW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_level   = r_wptr - r_rptr;
  assign o_full    = (o_level == FullLevel);
  assign o_empty   = (o_level == '0);
  // Push/pop are qualified against the registered level; no same-cycle bypass.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  // Head reads as zero when empty so the output is clean after a flush.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/tb_status_periph.sv
// Memory-mapped testbench status peripheral: stdout FIFO, sticky pass/fail
// verdict, exit code and a saturating cycle counter on the core data bus.
module tb_status_periph
  import tb_status_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = DEF_PASS_MAGIC,
  parameter logic [31:0] FAIL_MAGIC = DEF_FAIL_MAGIC
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tb_status_periph_if.slave    bus,
  output logic                 char_valid_o,
  output logic [7:0]           char_data_o,
  input  logic                 char_ready_i,
  output logic                 tests_passed_o,
  output logic                 tests_failed_o,
  output logic                 exit_valid_o,
  output logic [31:0]          exit_value_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e          w_sel;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_acc;
  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_verdict_open;
  logic [31:0]       w_rdata;
  logic              w_unused_bits;

  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic              r_passed;
  logic              r_failed;
  logic              r_exit_valid;
  logic [31:0]       r_exit_value;
  logic [31:0]       r_cycle;

  assign w_sel = decode_sel(bus.addr[31:4], BASE_ADDR[31:4], bus.addr[3:2]);

  // Only a PRINT write against a full FIFO is stalled.
  assign bus.gnt = bus.req & ~(bus.we & (w_sel == SEL_PRINT) & w_full);
  assign w_acc   = bus.gnt;
  assign w_wr    = w_acc & bus.we;
  assign w_push  = w_wr & (w_sel == SEL_PRINT) & bus.be[0];
  assign w_pop   = ~w_empty & char_ready_i;

  assign w_verdict_open = ~r_passed & ~r_failed;

  // Sub-word address bits and upper byte enables have no effect.
  assign w_unused_bits = ^{bus.be[3:1], bus.addr[1:0]};

  tb_char_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_wdata (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (char_data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign char_valid_o   = ~w_empty;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign exit_value_o   = r_exit_value;
  assign bus.rvalid     = r_rvalid;
  assign bus.rdata      = r_rdata;

  // Read data mux, evaluated in the grant cycle; writes return zero.
  always_comb begin
    w_rdata = '0;
    if (!bus.we) begin
      case (w_sel)
        SEL_PRINT:  w_rdata = 32'(w_level);
        SEL_STATUS: w_rdata = {30'b0, r_failed, r_passed};
        SEL_EXIT:   w_rdata = r_exit_value;
        SEL_CYCLE:  w_rdata = r_cycle;
        default:    w_rdata = '0;
      endcase
    end
  end

  // Response phase: one rvalid per grant, rdata zero whenever rvalid is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_acc;
      r_rdata  <= w_acc ? w_rdata : '0;
    end
  end

  // Sticky verdict: the first recognised STATUS write wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_passed <= 1'b0;
      r_failed <= 1'b0;
    end else if (w_wr && (w_sel == SEL_STATUS) && w_verdict_open) begin
      if (bus.wdata == PASS_MAGIC) begin
        r_passed <= 1'b1;
      end else if (bus.wdata == FAIL_MAGIC) begin
        r_failed <= 1'b1;
      end
    end
  end

  // Exit code latches on the first EXIT write only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exit_valid <= 1'b0;
      r_exit_value <= '0;
    end else if (w_wr && (w_sel == SEL_EXIT) && !r_exit_valid) begin
      r_exit_valid <= 1'b1;
      r_exit_value <= bus.wdata;
    end
  end

  // Free-running cycle counter, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle <= '0;
    end else if (r_cycle != '1) begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

endmodule

// File: tb/tb_tb_status_periph.sv
// Directed self-checking bench for tb_status_periph.
module tb_tb_status_periph;
  import tb_status_periph_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_ready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;

  int checks = 0;
  int failures = 0;

  tb_status_periph_if bus ();

  tb_status_periph #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .PASS_MAGIC (32'd123456789),
    .FAIL_MAGIC (32'd1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .char_valid_o   (char_valid),
    .char_data_o    (char_data),
    .char_ready_i   (char_ready),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exit_valid),
    .exit_value_o   (exit_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.be    = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  // One-cycle access: drive at negedge, sample gnt, then sample the response
  // just after the following rising edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic gnt, output logic rv,
                        output logic [31:0] rd);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.be    = be;
    #1 gnt = bus.gnt;
    @(posedge clk);
    #1;
    rv = bus.rvalid;
    rd = bus.rdata;
    idle_bus();
  endtask

  task automatic test_reset();
    logic g, rv;
    logic [31:0] rd;
    rst = 1'b1;
    char_ready = 1'b0;
    idle_bus();
    repeat (3) @(negedge clk);
    checks++;
    if ({passed, failed, exit_valid, char_valid, bus.rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {passed, failed, exit_valid, char_valid, bus.rvalid});
    end
    checks++;
    if (exit_value !== 32'h0) begin
      failures++; $display("FAIL reset_exit_value got=%h want=0", exit_value);
    end
    // Release reset and read CYCLE in the very first cycle after release.
    rst = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = BASE + 32'(OFF_CYCLE);
    #1;
    checks++;
    if ({bus.gnt, bus.rvalid} !== 2'b10) begin
      failures++; $display("FAIL reset_first_gnt got=%b want=10", {bus.gnt, bus.rvalid});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL cycle_first got=%b/%0d want=1/0", bus.rvalid, bus.rdata);
    end
    idle_bus();
    repeat (4) @(negedge clk);
    access(1'b0, BASE + 32'(OFF_CYCLE), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if ({g, rv, rd} !== {2'b11, 32'd5}) begin
      failures++; $display("FAIL cycle_plus5 got=%b%b/%0d want=11/5", g, rv, rd);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rvalid, bus.rdata} !== 33'h0) begin
      failures++; $display("FAIL rvalid_one_cycle got=%b/%h want=0/0", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_print();
    logic g, rv;
    logic [31:0] rd;
    logic [7:0] exp_chars [3];
    exp_chars[0] = 8'h48; exp_chars[1] = 8'h69; exp_chars[2] = 8'h0A;
    char_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      access(1'b1, BASE + 32'(OFF_PRINT), {24'h0, exp_chars[i]}, 4'h1, g, rv, rd);
      checks++;
      if ({g, rv, char_valid, char_data} !== {3'b111, exp_chars[i]}) begin
        failures++;
        $display("FAIL print_char%0d got=%b%b%b/%h want=111/%h", i, g, rv, char_valid,
                 char_data, exp_chars[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (char_valid !== 1'b0) begin
      failures++; $display("FAIL print_drained got=%b want=0", char_valid);
    end
    // PRINT write without byte lane 0: acknowledged, nothing queued.
    access(1'b1, BASE + 32'(OFF_PRINT), 32'h41, 4'b1110, g, rv, rd);
    checks++;
    if ({g, rv, char_valid} !== 3'b110) begin
      failures++; $display("FAIL print_be0_off got=%b%b%b want=110", g, rv, char_valid);
    end
  endtask

  task automatic test_full();
    logic g, rv;
    logic [31:0] rd;
    logic [7:0] exp_b;
    int bad_gnt;
    char_ready = 1'b0;
    bad_gnt = 0;
    for (int i = 0; i < 8; i++) begin
      access(1'b1, BASE + 32'(OFF_PRINT), 32'hA0 + 32'(i), 4'h1, g, rv, rd);
      if (g !== 1'b1) bad_gnt++;
    end
    checks++;
    if (bad_gnt != 0) begin
      failures++; $display("FAIL full_fill_gnts got=%0d_denied want=0_denied", bad_gnt);
    end
    access(1'b0, BASE + 32'(OFF_PRINT), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if (rd !== 32'd8) begin
      failures++; $display("FAIL full_level got=%0d want=8", rd);
    end
    // Ninth write stalls; one pop frees a slot for the next cycle.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.be = 4'h1;
    bus.addr = BASE + 32'(OFF_PRINT); bus.wdata = 32'hB9;
    char_ready = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, char_data} !== {1'b0, 8'hA0}) begin
      failures++; $display("FAIL full_stall got=%b/%h want=0/a0", bus.gnt, char_data);
    end
    @(negedge clk);
    char_ready = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, char_data} !== {1'b1, 8'hA1}) begin
      failures++; $display("FAIL full_retry got=%b/%h want=1/a1", bus.gnt, char_data);
    end
    @(posedge clk);
    #1;
    idle_bus();
    checks++;
    if (bus.rvalid !== 1'b1) begin
      failures++; $display("FAIL full_retry_rvalid got=%b want=1", bus.rvalid);
    end
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'hA1 + 8'(i) : 8'hB9;
      @(negedge clk);
      checks++;
      if ({char_valid, char_data} !== {1'b1, exp_b}) begin
        failures++;
        $display("FAIL drain%0d got=%b/%h want=1/%h", i, char_valid, char_data, exp_b);
      end
    end
    @(negedge clk);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty got=%b want=0", char_valid);
    end
    char_ready = 1'b0;
  endtask

  task automatic test_status();
    logic g, rv;
    logic [31:0] rd;
    access(1'b1, BASE + 32'(OFF_STATUS), 32'd5, 4'hF, g, rv, rd);
    checks++;
    if ({passed, failed} !== 2'b00) begin
      failures++; $display("FAIL status_other got=%b%b want=00", passed, failed);
    end
    access(1'b1, BASE + 32'(OFF_STATUS), 32'd123456789, 4'hF, g, rv, rd);
    checks++;
    if ({passed, failed} !== 2'b10) begin
      failures++; $display("FAIL status_pass got=%b%b want=10", passed, failed);
    end
    access(1'b1, BASE + 32'(OFF_STATUS), 32'd1, 4'hF, g, rv, rd);
    checks++;
    if ({passed, failed} !== 2'b10) begin
      failures++; $display("FAIL status_sticky got=%b%b want=10", passed, failed);
    end
    access(1'b0, BASE + 32'(OFF_STATUS), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("FAIL status_read got=%h want=1", rd);
    end
  endtask

  task automatic test_exit();
    logic g, rv;
    logic [31:0] rd;
    access(1'b1, BASE + 32'(OFF_EXIT), 32'h0000_0003, 4'b0001, g, rv, rd);
    checks++;
    if ({exit_valid, exit_value} !== {1'b1, 32'd3}) begin
      failures++; $display("FAIL exit_first got=%b/%h want=1/3", exit_valid, exit_value);
    end
    access(1'b1, BASE + 32'(OFF_EXIT), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if ({exit_valid, exit_value} !== {1'b1, 32'd3}) begin
      failures++; $display("FAIL exit_sticky got=%b/%h want=1/3", exit_valid, exit_value);
    end
    access(1'b0, BASE + 32'(OFF_EXIT), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if (rd !== 32'd3) begin
      failures++; $display("FAIL exit_read got=%h want=3", rd);
    end
    access(1'b0, BASE + 32'h10, 32'h0, 4'hF, g, rv, rd);
    checks++;
    if ({g, rv, rd} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL out_of_window got=%b%b/%h want=11/0", g, rv, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic g, rv;
    logic [31:0] rd;
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, BASE + 32'(OFF_PRINT), 32'hC0 + 32'(i), 4'h1, g, rv, rd);
    end
    access(1'b0, BASE + 32'(OFF_STATUS), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if ({rv, char_valid} !== 2'b11) begin
      failures++; $display("FAIL mid_pending got=%b%b want=11", rv, char_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rvalid, char_valid, passed, failed, exit_valid} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_flags got=%b want=00000",
               {bus.rvalid, char_valid, passed, failed, exit_valid});
    end
    checks++;
    if ({bus.rdata, exit_value, char_data} !== 72'h0) begin
      failures++;
      $display("FAIL mid_reset_data got=%h/%h/%h want=0/0/0", bus.rdata, exit_value, char_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rvalid !== 1'b0) begin
      failures++; $display("FAIL mid_no_rvalid got=%b want=0", bus.rvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = BASE + 32'(OFF_CYCLE);
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rvalid, bus.rdata} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL mid_cycle_restart got=%b/%0d want=1/0", bus.rvalid, bus.rdata);
    end
    idle_bus();
    access(1'b0, BASE + 32'(OFF_PRINT), 32'h0, 4'hF, g, rv, rd);
    checks++;
    if ({rd, char_valid} !== 33'h0) begin
      failures++; $display("FAIL mid_fifo_flushed got=%0d/%b want=0/0", rd, char_valid);
    end
  endtask

  initial begin
    test_reset();
    test_print();
    test_full();
    test_status();
    test_exit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
